// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and helpers for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int DEF_RA_W     = 5;
    localparam int DEF_T_W      = 2;
    localparam int DEF_NSTG     = 3;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int DEF_CNT_W    = 4;

    localparam logic [DEF_T_W-1:0] TUSE_NONE = '1;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// rtl/hazard_src_check.sv - stall/forward decision for one D-stage source operand
module hazard_src_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W  = DEF_RA_W,
    parameter int T_W   = DEF_T_W,
    parameter int NSTG  = DEF_NSTG,
    parameter int SEL_W = $clog2(DEF_NSTG + 1)
) (
    input  logic [RA_W-1:0]            src,
    input  logic [T_W-1:0]             tuse,
    input  logic [NSTG*(RA_W+T_W)-1:0] sb,
    output logic                       stall_src,
    output logic [SEL_W-1:0]           fwd_sel
);

    localparam int EW = RA_W + T_W;

    logic            found;
    logic [RA_W-1:0] ent_a3;
    logic [T_W-1:0]  ent_tnew;

    always_comb begin
        stall_src = 1'b0;
        fwd_sel   = SEL_W'(FWD_RF);
        found     = 1'b0;
        ent_a3    = '0;
        ent_tnew  = '0;
        // Youngest stage wins; older matches are shadowed.
        for (int k = 0; k < NSTG; k++) begin
            ent_a3   = sb[k*EW + T_W +: RA_W];
            ent_tnew = sb[k*EW +: T_W];
            if (!found && ent_a3 != '0 && ent_a3 == src) begin
                found = 1'b1;
                if (ent_tnew > tuse) begin
                    stall_src = 1'b1;
                end else if (ent_tnew == '0) begin
                    fwd_sel = SEL_W'(k + 1);
                end
            end
        end
        if (src == '0 || tuse == {T_W{1'b1}}) begin
            stall_src = 1'b0;
            fwd_sel   = SEL_W'(FWD_RF);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew hazard unit with forwarding selects and HI/LO busy interlock
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W     = DEF_RA_W,
    parameter int T_W      = DEF_T_W,
    parameter int NSTG     = DEF_NSTG,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         d_valid,
    input  logic [RA_W-1:0]              d_rs,
    input  logic [RA_W-1:0]              d_rt,
    input  logic [T_W-1:0]               d_tuse_rs,
    input  logic [T_W-1:0]               d_tuse_rt,
    input  logic [RA_W-1:0]              d_a3,
    input  logic [T_W-1:0]               d_tnew,
    input  logic                         d_md_start,
    input  logic                         d_md_div,
    input  logic                         d_md_use,
    output logic                         stall,
    output logic [$clog2(NSTG+1)-1:0]    fwd_rs_sel,
    output logic [$clog2(NSTG+1)-1:0]    fwd_rt_sel,
    output logic                         md_busy
);

    localparam int EW    = RA_W + T_W;
    localparam int SEL_W = $clog2(NSTG + 1);

    logic [RA_W-1:0]      a3_q   [NSTG];
    logic [T_W-1:0]       tnew_q [NSTG];
    logic [NSTG*EW-1:0]   sb_flat;
    logic [CNT_W-1:0]     busy_cnt;
    logic                 rs_stall;
    logic                 rt_stall;
    logic                 md_stall;
    logic                 issue;

    always_comb begin
        sb_flat = '0;
        for (int k = 0; k < NSTG; k++) begin
            sb_flat[k*EW +: EW] = {a3_q[k], tnew_q[k]};
        end
    end

    hazard_src_check #(.RA_W(RA_W), .T_W(T_W), .NSTG(NSTG), .SEL_W(SEL_W)) u_rs_check (
        .src       (d_rs),
        .tuse      (d_tuse_rs),
        .sb        (sb_flat),
        .stall_src (rs_stall),
        .fwd_sel   (fwd_rs_sel)
    );

    hazard_src_check #(.RA_W(RA_W), .T_W(T_W), .NSTG(NSTG), .SEL_W(SEL_W)) u_rt_check (
        .src       (d_rt),
        .tuse      (d_tuse_rt),
        .sb        (sb_flat),
        .stall_src (rt_stall),
        .fwd_sel   (fwd_rt_sel)
    );

    assign md_busy  = (busy_cnt != '0);
    assign md_stall = d_valid & (d_md_start | d_md_use) & md_busy;
    assign stall    = rs_stall | rt_stall | md_stall;
    assign issue    = d_valid & ~stall;

    // A stalled D instruction leaves a bubble in E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTG; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            a3_q[0]   <= issue ? d_a3 : '0;
            tnew_q[0] <= issue ? d_tnew : '0;
            for (int k = 1; k < NSTG; k++) begin
                a3_q[k]   <= a3_q[k-1];
                tnew_q[k] <= T_W'(sat_dec(32'(tnew_q[k-1])));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt <= '0;
        end else if (issue && d_md_start) begin
            busy_cnt <= d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       md_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] a3, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
        d_a3 = a3; d_tnew = tn; d_md_start = ms; d_md_div = md; d_md_use = mu;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_rs_sel", fwd_rs_sel, FWD_RF);
        check("rst_rt_sel", fwd_rt_sel, FWD_RF);
        check("rst_md_busy", md_busy, 0);
        tick();

        // lw $8 then addu reading $8
        drive(1, 5'd29, 5'd0, 2'd1, TUSE_NONE, 5'd8, 2'd2, 0, 0, 0);
        #1 check("lw_stall", stall, 0);
        tick();
        drive(1, 5'd8, 5'd0, 2'd1, 2'd1, 5'd10, 2'd1, 0, 0, 0);
        #1 check("lw_use_stall", stall, 1);
        tick();
        #1 check("lw_use_release", stall, 0);
        check("lw_use_m_sel", fwd_rs_sel, FWD_RF);
        tick();
        drive(1, 5'd8, 5'd8, 2'd1, 2'd0, 5'd11, 2'd1, 0, 0, 0);
        #1 check("lw_w_stall", stall, 0);
        check("lw_w_rs_sel", fwd_rs_sel, FWD_W);
        check("lw_w_rt_sel", fwd_rt_sel, FWD_W);
        tick();
        flush();

        // ori $9 then beq $9,$9
        drive(1, 5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd9, 2'd1, 0, 0, 0);
        tick();
        drive(1, 5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        #1 check("beq_stall", stall, 1);
        tick();
        #1 check("beq_release", stall, 0);
        check("beq_rs_sel", fwd_rs_sel, FWD_M);
        check("beq_rt_sel", fwd_rt_sel, FWD_M);
        tick();
        flush();

        // shadowing: addu $5, ori $5, reader must take the younger copy
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, 2'd1, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, 2'd1, 0, 0, 0);
        #1 check("shadow_ori_stall", stall, 0);
        tick();
        drive(1, 5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        #1 check("shadow_stall", stall, 1);
        tick();
        #1 check("shadow_release", stall, 0);
        check("shadow_sel_m", fwd_rs_sel, FWD_M);
        tick();
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, 2'd0, 0, 0, 0);
        tick();
        drive(1, 5'd5, 5'd5, 2'd0, 2'd1, 5'd0, 2'd0, 0, 0, 0);
        #1 check("e_fwd_stall", stall, 0);
        check("e_fwd_rs_sel", fwd_rs_sel, FWD_E);
        check("e_fwd_rt_sel", fwd_rt_sel, FWD_E);
        tick();
        flush();

        // writes to $0 never create hazards
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd2, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        #1 check("zero_stall", stall, 0);
        check("zero_rs_sel", fwd_rs_sel, FWD_RF);
        tick();
        flush();

        // unused rt operand against a pending lw $8
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd2, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd8, 2'd0, TUSE_NONE, 5'd0, 2'd0, 0, 0, 0);
        #1 check("unused_stall", stall, 0);
        check("unused_rt_sel", fwd_rt_sel, FWD_RF);
        tick();
        flush();

        // div, second div while busy, then mflo
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1, 1, 0);
        #1 check("div_issue_stall", stall, 0);
        check("div_issue_busy", md_busy, 0);
        tick();
        #1 check("div_busy", md_busy, 1);
        check("div2_stall", stall, 1);
        cnt = 1;
        tick();
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) break;
            cnt++;
            tick();
        end
        check("div_stall_cycles", cnt, 10);
        check("div_done_busy", md_busy, 0);
        tick();

        // mult after idle loads MULT_LAT
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1, 0, 0);
        #1 check("mult_issue_stall", stall, 0);
        tick();
        idle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!md_busy) break;
            cnt++;
            tick();
        end
        check("mult_busy_cycles", cnt, 5);
        flush();

        // asynchronous reset while a data stall and a mult are pending
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd2, 0, 0, 0);
        tick();
        drive(1, 5'd8, 5'd0, 2'd1, TUSE_NONE, 5'd10, 2'd1, 0, 0, 0);
        #1 check("pre_rst_stall", stall, 1);
        check("pre_rst_busy", md_busy, 1);
        #1 reset_n = 1'b0;
        #1 check("async_rst_stall", stall, 0);
        check("async_rst_rs_sel", fwd_rs_sel, FWD_RF);
        check("async_rst_busy", md_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        drive(1, 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0);
        #1 check("post_rst_stall", stall, 0);
        check("post_rst_rs_sel", fwd_rs_sel, FWD_RF);
        check("post_rst_rt_sel", fwd_rt_sel, FWD_RF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
